// File: rtl/select_scheduler.sv
// Steps a select index through the enabled slots of a latched mask, holding each for DWELL cycles.
// Build option: define SELECT_SCHED_LOOP_EN to repeat passes until abort/reset instead of returning to IDLE.
module select_scheduler #(
  parameter int unsigned DWELL   = 1562500,
  parameter int unsigned NUM_SEL = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [NUM_SEL-1:0] slot_mask,
  output logic [3:0]         select,
  output logic               busy,
  output logic               slot_end,
  output logic               done
);

  localparam logic [23:0] DWELL_LAST = 24'(DWELL - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [3:0]         select_q, select_d;
  logic [23:0]        count_q, count_d;
  logic [NUM_SEL-1:0] mask_q, mask_d;
  logic               done_q, done_d;

  logic [3:0] first_in_idx, first_latched_idx, next_idx;
  logic       has_next;
  logic       slot_end_int;

  // Descending scans so the lowest qualifying index wins.
  always_comb begin
    first_in_idx      = 4'd0;
    first_latched_idx = 4'd0;
    next_idx          = 4'd0;
    has_next          = 1'b0;
    for (int i = int'(NUM_SEL) - 1; i >= 0; i--) begin
      if (slot_mask[i]) first_in_idx = 4'(i);
      if (mask_q[i]) first_latched_idx = 4'(i);
      if (mask_q[i] && (i > int'(select_q))) begin
        next_idx = 4'(i);
        has_next = 1'b1;
      end
    end
  end

  assign slot_end_int = (state_q == RUN) && (count_q == DWELL_LAST) && !pause && !abort;

  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    count_d  = count_q;
    mask_d   = mask_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (|slot_mask) begin
            mask_d   = slot_mask;
            state_d  = RUN;
            select_d = first_in_idx;
            count_d  = 24'd0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          select_d = 4'd0;
          count_d  = 24'd0;
        end else if (slot_end_int) begin
          count_d = 24'd0;
          if (has_next) begin
            select_d = next_idx;
          end else begin
            done_d = 1'b1;
`ifdef SELECT_SCHED_LOOP_EN
            select_d = first_latched_idx;
`else
            state_d  = IDLE;
            select_d = 4'd0;
`endif
          end
        end else if (!pause) begin
          count_d = count_q + 24'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        select_d = 4'd0;
        count_d  = 24'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      select_q <= 4'd0;
      count_q  <= 24'd0;
      mask_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
      done_q   <= done_d;
    end
  end

  assign select   = select_q;
  assign busy     = (state_q == RUN);
  assign slot_end = slot_end_int;
  assign done     = done_q;

endmodule

// File: tb/tb_select_scheduler.sv
// Bench for select_scheduler (DWELL=4, NUM_SEL=10): directed table, pass sequences, random vs. queue-based model.
module tb_select_scheduler;

  localparam int DWELL = 4;
`ifdef SELECT_SCHED_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [9:0] slot_mask = '0;
  logic [3:0] select;
  logic       busy, slot_end, done;

  select_scheduler #(.DWELL(DWELL), .NUM_SEL(10)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .pause(pause),
    .slot_mask(slot_mask), .select(select), .busy(busy), .slot_end(slot_end), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: list of enabled slots, position in it, cycles spent in current slot.
  bit   m_valid = 1'b0;
  bit   m_run = 1'b0;
  bit   m_done = 1'b0;
  int   m_seq[$];
  int   m_pos = 0;
  int   m_elapsed = 0;

  logic [3:0] obs_sel;
  logic       obs_busy, obs_se, obs_done;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endfunction

  task automatic model_edge(input logic rst, input logic st, input logic ab, input logic pa,
                            input logic [9:0] mk);
    if (rst) begin
      m_valid = 1'b1; m_run = 1'b0; m_done = 1'b0; m_pos = 0; m_elapsed = 0;
      m_seq.delete();
    end else if (!m_run) begin
      m_done = 1'b0;
      if (st) begin
        if (mk != 10'd0) begin
          m_seq.delete();
          for (int i = 0; i < 10; i++) if (mk[i]) m_seq.push_back(i);
          m_pos = 0; m_elapsed = 0; m_run = 1'b1;
        end else begin
          m_done = 1'b1;
        end
      end
    end else begin
      m_done = 1'b0;
      if (ab) begin
        m_run = 1'b0;
      end else if (!pa && m_elapsed == DWELL - 1) begin
        m_elapsed = 0;
        if (m_pos + 1 < m_seq.size()) begin
          m_pos++;
        end else begin
          m_done = 1'b1;
          m_pos = 0;
          if (!LOOP) m_run = 1'b0;
        end
      end else if (!pa) begin
        m_elapsed++;
      end
    end
  endtask

  // Drive inputs after the falling edge, check against the model, then advance on the rising edge.
  task automatic step(input logic rst, input logic st, input logic ab, input logic pa,
                      input logic [9:0] mk);
    logic [3:0] p_sel;
    logic       p_se;
    @(negedge clk);
    reset = rst; start = st; abort = ab; pause = pa; slot_mask = mk;
    #1;
    obs_sel = select; obs_busy = busy; obs_se = slot_end; obs_done = done;
    if (m_valid) begin
      p_sel = m_run ? 4'(m_seq[m_pos]) : 4'd0;
      p_se  = m_run && (m_elapsed == DWELL - 1) && !pa && !ab;
      chk("model_select", 32'(obs_sel), 32'(p_sel));
      chk("model_busy", 32'(obs_busy), 32'(m_run));
      chk("model_slot_end", 32'(obs_se), 32'(p_se));
      chk("model_done", 32'(obs_done), 32'(m_done));
    end
    @(posedge clk);
    model_edge(rst, st, ab, pa, mk);
  endtask

  // One non-looping pass from IDLE: per-cycle select, busy length, slot_end count, done timing.
  task automatic run_pass(input logic [9:0] mk, input string nm);
    int seq[$];
    int busy_cnt, se_cnt, done_at, limit;
    for (int i = 0; i < 10; i++) if (mk[i]) seq.push_back(i);
    busy_cnt = 0; se_cnt = 0; done_at = -1;
    limit = DWELL * seq.size() + 10;
    step(0, 1, 0, 0, mk);
    for (int k = 1; k <= limit; k++) begin
      step(0, 0, 0, 0, mk);
      if (obs_busy) begin
        chk({nm, "_select"}, 32'(obs_sel), 32'(seq[busy_cnt / DWELL]));
        busy_cnt++;
      end
      if (obs_se) se_cnt++;
      if (obs_done) begin
        done_at = k;
        chk({nm, "_idle_at_done"}, 32'(obs_busy), 32'(0));
        break;
      end
    end
    chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(DWELL * seq.size()));
    chk({nm, "_slot_end_count"}, 32'(se_cnt), 32'(seq.size()));
    chk({nm, "_done_cycle"}, 32'(done_at), 32'(DWELL * seq.size() + 1));
  endtask

  typedef struct {
    logic       st, ab, pa;
    logic [9:0] mk;
    logic [3:0] e_sel;
    logic       e_busy, e_se, e_done;
  } vec_t;

  vec_t tbl[17];

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 10'h000, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 10'h202, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 10'h3FF, 4'd1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 10'h3FF, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 10'h3FF, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 10'h000, 4'd9, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd9, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 10'h000, LOOP ? 4'd1 : 4'd0, LOOP, 1'b0, 1'b1};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 10'h000, LOOP ? 4'd1 : 4'd0, LOOP, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 10'h000, 4'd0, 1'b0, 1'b0, 1'b0};

    step(1, 0, 0, 0, 10'h000);
    step(1, 1, 0, 0, 10'h3FF);
    chk("reset_select", 32'(obs_sel), 32'(0));

    foreach (tbl[i]) begin
      step(0, tbl[i].st, tbl[i].ab, tbl[i].pa, tbl[i].mk);
      chk($sformatf("tbl%0d_select", i), 32'(obs_sel), 32'(tbl[i].e_sel));
      chk($sformatf("tbl%0d_busy", i), 32'(obs_busy), 32'(tbl[i].e_busy));
      chk($sformatf("tbl%0d_slot_end", i), 32'(obs_se), 32'(tbl[i].e_se));
      chk($sformatf("tbl%0d_done", i), 32'(obs_done), 32'(tbl[i].e_done));
    end

`ifndef SELECT_SCHED_LOOP_EN
    run_pass(10'h3FF, "full");
    run_pass(10'h211, "sparse");

    begin
      int slot2 = 0;
      step(0, 1, 0, 0, 10'h3FF);
      for (int k = 1; k <= 21; k++) begin
        step(0, 0, (k == 19), (k >= 10 && k <= 12), 10'h3FF);
        if (k <= 18 && obs_busy && obs_sel == 4'd2) slot2++;
        if (k == 19) begin
          chk("abort_slot_sel", 32'(obs_sel), 32'(3));
          chk("abort_beats_slot_end", 32'(obs_se), 32'(0));
        end
        if (k == 20) begin
          chk("abort_idle_busy", 32'(obs_busy), 32'(0));
          chk("abort_idle_select", 32'(obs_sel), 32'(0));
        end
        if (k >= 20) chk("abort_no_done", 32'(obs_done), 32'(0));
      end
      chk("pause_slot2_len", 32'(slot2), 32'(7));
    end

    step(0, 1, 0, 0, 10'h3FF);
    for (int k = 1; k <= 22; k++) begin
      step(k == 22, 0, 0, 0, 10'h3FF);
      if (k == 22) chk("pre_reset_sel", 32'(obs_sel), 32'(5));
    end
    step(0, 0, 0, 0, 10'h3FF);
    chk("post_reset_select", 32'(obs_sel), 32'(0));
    chk("post_reset_busy", 32'(obs_busy), 32'(0));
    chk("post_reset_done", 32'(obs_done), 32'(0));
    run_pass(10'h3FF, "after_reset");
`else
    step(0, 1, 0, 0, 10'h006);
    for (int k = 1; k <= 30; k++) begin
      step(0, 0, 0, 0, 10'h006);
      chk("loop_busy", 32'(obs_busy), 32'(1));
      chk("loop_select", 32'(obs_sel), ((((k - 1) / 4) % 2) == 1) ? 32'd2 : 32'd1);
      chk("loop_done", 32'(obs_done), 32'((k > 1) && (((k - 1) % 8) == 0)));
    end
    step(0, 0, 1, 0, 10'h006);
    step(0, 0, 0, 0, 10'h006);
    chk("loop_abort_busy", 32'(obs_busy), 32'(0));
    chk("loop_abort_done", 32'(obs_done), 32'(0));
`endif

    for (int n = 0; n < 3000; n++) begin
      logic       r_rst, r_st, r_ab, r_pa;
      logic [9:0] r_mk;
      r_rst = ($urandom_range(0, 199) == 0);
      r_st  = ($urandom_range(0, 7) == 0);
      r_ab  = ($urandom_range(0, 39) == 0);
      r_pa  = ($urandom_range(0, 4) == 0);
      r_mk  = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom);
      step(r_rst, r_st, r_ab, r_pa, r_mk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/select_scheduler.md
SELECT_SCHEDULER -- requirements
Module: select_scheduler

Interface
REQ-001 Parameter: DWELL, default 1562500, cycles each slot stays selected; legal range 1..2^24.
REQ-002 Parameter: NUM_SEL, default 10, number of selectable slots; legal range 1..16.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 Port: start  input  1  request one sequencing pass; sampled only in IDLE.
REQ-006 Port: abort  input  1  terminate the current pass.
REQ-007 Port: pause  input  1  freeze the dwell counter while high.
REQ-008 Port: slot_mask  input  NUM_SEL  per-slot enable; bit i = slot i; latched on accepted start.
REQ-009 Port: select  output  4  current slot index.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: slot_end  output  1  high during the final dwell cycle of a slot.
REQ-012 Port: done  output  1  one-cycle pulse on pass completion.

Function
REQ-013 States are IDLE and RUN; dwell counter is 24 bits, unsigned.
REQ-014 In IDLE: select=0, busy=0, slot_end=0, counter=0.
REQ-015 start=1 in IDLE with slot_mask!=0: latch mask; next cycle is RUN, select = lowest set bit index, counter=0, busy=1.
REQ-016 start=1 in IDLE with slot_mask==0: remain IDLE; done=1 the following cycle.
REQ-017 start is ignored while busy=1.
REQ-018 In RUN: the counter increments by 1 on each cycle with pause=0; it holds when pause=1.
REQ-019 slot_end = RUN and counter==DWELL-1 and pause==0 and abort==0; it is decoded combinationally from registers and inputs.
REQ-020 On a slot_end edge, select moves to the next latched-mask bit with index > current and the counter clears to 0.
REQ-021 Disabled slots are skipped with zero dead cycles.
REQ-022 If no higher enabled slot exists on slot_end, the pass completes: done=1 for exactly the next cycle (behaviour per REQ-029/REQ-030).
REQ-023 abort=1 in RUN: next cycle is IDLE, select=0, counter=0, and no done pulse.
REQ-024 abort has priority over slot_end and pause in the same cycle.
REQ-025 abort in IDLE has no effect.
REQ-026 DWELL=1: each enabled slot is selected for exactly one cycle, and slot_end is high on every unpaused RUN cycle.
REQ-027 Changes to slot_mask during RUN have no effect until the next accepted start.

Reset
REQ-028 reset=1 forces IDLE on the next edge, from any state, including mid-dwell and mid-pause: select=0, busy=0, done=0, counter=0, latched mask=0. reset has priority over all other inputs.

Configuration
REQ-029 Macro SELECT_SCHED_LOOP_EN defined: on pass completion, select wraps to the lowest enabled latched slot, the counter clears, the block stays in RUN with busy=1, and done pulses once per pass; only abort or reset return it to IDLE.
REQ-030 Macro SELECT_SCHED_LOOP_EN undefined: on pass completion the block enters IDLE, with select=0 and busy=0 in the same cycle that done=1.

Verification
All scenarios use DWELL=4, NUM_SEL=10, loop disabled unless stated.
REQ-031 Full pass: start with mask=0x3FF -> select is 0..9, each held for 4 cycles; slot_end fires 10 times; done fires at cycle 41 after start; busy is high for 40 cycles.
REQ-032 Sparse mask: start with mask=0x211 -> select sequence is 0,4,9 with no gap cycles; done fires after 12 RUN cycles.
REQ-033 Pause and abort: pause held 3 cycles mid-slot 2 -> slot 2 lasts 7 cycles; abort on a slot_end cycle -> IDLE next cycle, select=0, no done pulse.
REQ-034 Zero mask and busy start: start with mask=0 -> done 1 cycle later, busy never high; start pulsed while busy -> no effect on the sequence.
REQ-035 Reset mid-dwell in slot 5 -> next cycle select=0, busy=0; a subsequent start behaves per REQ-031.
REQ-036 With SELECT_SCHED_LOOP_EN defined, mask=0x006 -> sequence 1,2,1,2,... with done pulsing every 8 cycles until abort.
